// File: rtl/mtm_alu_pkg.sv
// Shared constants for the MTM-ALU serial receive path: packet types, receiver
// states, control codes, opcodes and the CRC4 step function.
package mtm_alu_pkg;

    localparam int DEF_DATA_PKTS = 8;

    localparam logic [7:0] CTL_IDLE     = 8'hFF;
    localparam logic [7:0] CTL_ERR_DATA = 8'hC9;
    localparam logic [7:0] CTL_ERR_CRC  = 8'hA5;

    // x^4 + x + 1 with the x^4 term implicit
    localparam logic [3:0] CRC4_POLY = 4'b0011;

    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CMD  = 1'b1
    } pkt_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_PAYLOAD,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_e;

    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic d);
        logic fb;
        fb = crc[3] ^ d;
        return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    endfunction

endpackage

// File: rtl/mtm_crc4_serial.sv
// Serial CRC4 LFSR, one bit per enabled cycle, MSB first; clr wins over en.
module mtm_crc4_serial
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       d,
    output logic [3:0] crc
);

    logic [3:0] crc_q;
    logic [3:0] crc_d;

    // NOTE: combinational blocks assign a default first so no path leaves a latch.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 4'b0000;
        end else if (en) begin
            crc_d = crc4_step(crc_q, d);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 4'b0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Receive stage ahead of the ALU core: deserializes B/A data packets and the
// command packet, checks CRC4 and presents A/B/CTL for one cycle per frame.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int         DATA_PKTS    = DEF_DATA_PKTS,
    parameter logic [7:0] IDLE_CTL     = CTL_IDLE,
    parameter logic [7:0] ERR_DATA_CTL = CTL_ERR_DATA,
    parameter logic [7:0] ERR_CRC_CTL  = CTL_ERR_CRC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [7:0]  CTL,
    output logic        out_valid
);

    localparam int               CNT_W    = $clog2(DATA_PKTS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_PKTS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_PKTS + 1);

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q;
    pkt_type_e        type_q;
    logic [7:0]       pay_q;
    logic [63:0]      sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      a_q, b_q;
    logic [7:0]       ctl_q, ctl_d;
    logic             valid_q, valid_d;

    logic       pay_shift;
    logic       data_accept;
    logic       frame_end;
    logic       stop_err;
    logic       load_ab;
    logic       crc_clr;
    logic       crc_en;
    logic       crc_bit;
    logic [3:0] crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (!sin) state_d = ST_TYPE;
            ST_TYPE:      state_d = ST_PAYLOAD;
            ST_PAYLOAD:   if (bit_cnt_q == 3'd7) state_d = ST_STOP;
            ST_STOP:      state_d = sin ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (sin) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pay_shift   = (state_q == ST_PAYLOAD);
        data_accept = (state_q == ST_STOP) && sin && (type_q == PKT_DATA);
        frame_end   = (state_q == ST_STOP) && sin && (type_q == PKT_CMD);
        stop_err    = (state_q == ST_STOP) && !sin;
        crc_clr     = frame_end || stop_err;

        // CMD bit7 slot carries the implied 1'b1; OP follows, received CRC is skipped
        crc_en  = 1'b0;
        crc_bit = sin;
        if (state_q == ST_PAYLOAD) begin
            if (type_q == PKT_DATA) begin
                crc_en = 1'b1;
            end else if (bit_cnt_q == 3'd0) begin
                crc_en  = 1'b1;
                crc_bit = 1'b1;
            end else if (bit_cnt_q <= 3'd3) begin
                crc_en = 1'b1;
            end
        end

        valid_d = 1'b0;
        ctl_d   = IDLE_CTL;
        load_ab = 1'b0;
        if (stop_err) begin
            valid_d = 1'b1;
            ctl_d   = ERR_DATA_CTL;
        end else if (frame_end) begin
            valid_d = 1'b1;
            if (cnt_q != CNT_FULL) begin
                ctl_d = ERR_DATA_CTL;
            end else if (crc != pay_q[3:0]) begin
                ctl_d = ERR_CRC_CTL;
            end else begin
                ctl_d   = pay_q;
                load_ab = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            type_q    <= PKT_DATA;
            pay_q     <= 8'h00;
            sr_q      <= 64'h0;
            cnt_q     <= '0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            ctl_q     <= IDLE_CTL;
            valid_q   <= 1'b0;
        end else begin
            ctl_q   <= ctl_d;
            valid_q <= valid_d;

            if (state_q == ST_TYPE) begin
                type_q    <= pkt_type_e'(sin);
                bit_cnt_q <= 3'd0;
            end
            if (pay_shift) begin
                pay_q     <= {pay_q[6:0], sin};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (data_accept) begin
                sr_q <= {sr_q[55:0], pay_q};
                if (cnt_q != CNT_SAT) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (crc_clr) begin
                cnt_q <= '0;
            end

            if (load_ab) begin
                b_q <= sr_q[63:32];
                a_q <= sr_q[31:0];
            end
        end
    end

    mtm_crc4_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .d   (crc_bit),
        .crc (crc)
    );

    assign A         = a_q;
    assign B         = b_q;
    assign CTL       = ctl_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed self-checking bench for mtm_alu_deserializer: good frames, CRC and
// count errors, back-to-back frames, bad stop bit and mid-frame reset.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] A;
    logic [31:0] B;
    logic [7:0]  CTL;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;
    logic [7:0] cmd;

    mtm_alu_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .A         (A),
        .B         (B),
        .CTL       (CTL),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, return just after the sampling edge
    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] payload, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(payload[i]);
        send_bit(stop);
    endtask

    task automatic send_operands(input logic [31:0] b, input logic [31:0] a);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, b[i*8 +: 8], 1'b1);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, a[i*8 +: 8], 1'b1);
    endtask

    function automatic logic [7:0] make_cmd(input logic [31:0] b, input logic [31:0] a,
                                            input logic [2:0] op);
        logic [67:0] bits;
        logic [3:0]  c;
        logic        fb;
        bits = {b, a, 1'b1, op};
        c    = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ bits[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return {1'b0, op, c};
    endfunction

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_A", A, 32'h0);
        check("reset_B", B, 32'h0);
        check("reset_CTL", {24'h0, CTL}, 32'hFF);
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);

        // All-zero operands, OP=AND, CRC=1011
        send_operands(32'h0, 32'h0);
        send_pkt(1'b1, 8'h0B, 1'b1);
        check("zero_CTL", {24'h0, CTL}, 32'h0B);
        check("zero_valid", {31'h0, out_valid}, 32'h1);
        check("zero_A", A, 32'h0);
        check("zero_B", B, 32'h0);
        send_bit(1'b1);
        check("zero_CTL_idle", {24'h0, CTL}, 32'hFF);
        check("zero_valid_drop", {31'h0, out_valid}, 32'h0);

        // OP=ADD, CRC=0111
        send_operands(32'h0, 32'h0);
        send_pkt(1'b1, 8'h47, 1'b1);
        check("add_CTL", {24'h0, CTL}, 32'h47);
        send_bit(1'b1);

        // B=2, A=1, OP=ADD: hand-derived CRC 1100, then a second frame back-to-back
        p0 = pulses;
        send_operands(32'h2, 32'h1);
        send_pkt(1'b1, 8'h4C, 1'b1);
        check("b2b1_CTL", {24'h0, CTL}, 32'h4C);
        check("b2b1_A", A, 32'h1);
        check("b2b1_B", B, 32'h2);
        cmd = make_cmd(32'hDEADBEEF, 32'h12345678, 3'b001);
        send_operands(32'hDEADBEEF, 32'h12345678);
        send_pkt(1'b1, cmd, 1'b1);
        check("b2b2_CTL", {24'h0, CTL}, {24'h0, cmd});
        check("b2b2_A", A, 32'h12345678);
        check("b2b2_B", B, 32'hDEADBEEF);
        send_bit(1'b1);
        check("b2b_pulses", pulses - p0, 32'd2);

        // Bad CRC: A/B must hold the previous frame
        send_operands(32'h0, 32'h0);
        send_pkt(1'b1, 8'h4A, 1'b1);
        check("crc_CTL", {24'h0, CTL}, 32'hA5);
        check("crc_valid", {31'h0, out_valid}, 32'h1);
        check("crc_A_hold", A, 32'h12345678);
        check("crc_B_hold", B, 32'hDEADBEEF);
        send_bit(1'b1);

        // Seven data packets
        for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'h00, 1'b1);
        send_pkt(1'b1, 8'h0B, 1'b1);
        check("short_CTL", {24'h0, CTL}, 32'hC9);
        check("short_A_hold", A, 32'h12345678);
        send_bit(1'b1);

        // Nine data packets
        for (int i = 0; i < 9; i++) send_pkt(1'b0, 8'h00, 1'b1);
        send_pkt(1'b1, 8'h0B, 1'b1);
        check("long_CTL", {24'h0, CTL}, 32'hC9);
        send_bit(1'b1);

        cmd = make_cmd(32'h0F0F0001, 32'h80000000, 3'b101);
        send_operands(32'h0F0F0001, 32'h80000000);
        send_pkt(1'b1, cmd, 1'b1);
        check("after_cnt_CTL", {24'h0, CTL}, {24'h0, cmd});
        check("after_cnt_A", A, 32'h80000000);
        check("after_cnt_B", B, 32'h0F0F0001);
        send_bit(1'b1);

        // Bad stop bit on a data packet, line held low afterwards
        send_pkt(1'b0, 8'h00, 1'b1);
        send_pkt(1'b0, 8'h5A, 1'b0);
        check("stop_CTL", {24'h0, CTL}, 32'hC9);
        check("stop_valid", {31'h0, out_valid}, 32'h1);
        send_bit(1'b0);
        check("stop_CTL_idle", {24'h0, CTL}, 32'hFF);
        check("stop_valid_drop", {31'h0, out_valid}, 32'h0);
        send_bit(1'b0);
        send_bit(1'b1);
        cmd = make_cmd(32'hCAFEF00D, 32'h0BADBEEF, 3'b000);
        send_operands(32'hCAFEF00D, 32'h0BADBEEF);
        send_pkt(1'b1, cmd, 1'b1);
        check("after_stop_CTL", {24'h0, CTL}, {24'h0, cmd});
        check("after_stop_A", A, 32'h0BADBEEF);
        check("after_stop_B", B, 32'hCAFEF00D);
        send_bit(1'b1);

        // Reset in the middle of the 5th data packet
        for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'hA1 + 8'(i), 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        sin = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_A", A, 32'h0);
        check("mid_rst_B", B, 32'h0);
        check("mid_rst_CTL", {24'h0, CTL}, 32'hFF);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1);
        cmd = make_cmd(32'h11223344, 32'h55667788, 3'b101);
        send_operands(32'h11223344, 32'h55667788);
        send_pkt(1'b1, cmd, 1'b1);
        check("post_rst_CTL", {24'h0, CTL}, {24'h0, cmd});
        check("post_rst_A", A, 32'h55667788);
        check("post_rst_B", B, 32'h11223344);
        send_bit(1'b1);
        check("post_rst_idle", {24'h0, CTL}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
